// File: rtl/fsm_state_sequencer.sv
// Registered state stage behind the next-state priority encoder: valid/ack intake, dwell timer, binary/one-hot publish.
// Optional transition history (prev_state, trans_count) is built only when FSM_SEQ_HISTORY_EN is defined.
module fsm_state_sequencer #(
    parameter int DWELL_W   = 4,
    parameter int MIN_DWELL = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_next_state,
    input  logic               i_next_valid,
    input  logic               i_hold,
    output logic [1:0]         o_cur_state,
    output logic [3:0]         o_state_onehot,
    output logic               o_trans_ack,
    output logic               o_busy,
    output logic [DWELL_W-1:0] o_dwell_cnt,
    output logic [1:0]         o_prev_state,
    output logic [7:0]         o_trans_count
);

    localparam logic [DWELL_W-1:0] LP_MIN_DWELL = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0] LP_ONE       = DWELL_W'(1);
    localparam bit                 LP_HAS_DWELL = (MIN_DWELL != 0);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } ctrl_t;

    typedef struct packed {
        logic [1:0] state;
        logic       valid;
    } req_t;

    ctrl_t              r_ctrl;
    ctrl_t              w_ctrl_nxt;
    req_t               w_req;
    logic [1:0]         r_cur_state;
    logic [1:0]         w_cur_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               r_trans_ack;
    logic               w_ack_nxt;
    logic               w_busy;
    logic               w_accept;
    logic               w_real;
    logic [3:0]         w_onehot;

    assign w_req    = {i_next_state, i_next_valid};
    assign w_busy   = (r_dwell_cnt != '0);
    // !ack blocks the edge right after an accept, giving the requester a cycle to drop valid
    assign w_accept = w_req.valid & ~i_hold & ~w_busy & ~r_trans_ack;
    assign w_real   = w_accept & (w_req.state != r_cur_state);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl <= ST_IDLE;
        end else begin
            r_ctrl <= w_ctrl_nxt;
        end
    end

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        case (r_ctrl)
            ST_IDLE: begin
                if (w_real && LP_HAS_DWELL) begin
                    w_ctrl_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!i_hold && (r_dwell_cnt == LP_ONE)) begin
                    w_ctrl_nxt = ST_IDLE;
                end
            end
            default: w_ctrl_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cur_nxt   = r_cur_state;
        w_dwell_nxt = r_dwell_cnt;
        w_ack_nxt   = w_accept;
        if (w_real) begin
            w_cur_nxt   = w_req.state;
            w_dwell_nxt = LP_MIN_DWELL;
        end else if ((r_ctrl == ST_DWELL) && w_busy && !i_hold) begin
            w_dwell_nxt = r_dwell_cnt - LP_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_state <= 2'b00;
            r_dwell_cnt <= '0;
            r_trans_ack <= 1'b0;
        end else begin
            r_cur_state <= w_cur_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_trans_ack <= w_ack_nxt;
        end
    end

`ifdef FSM_SEQ_HISTORY_EN
    logic [1:0] r_prev_state;
    logic [7:0] r_trans_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_state  <= 2'b00;
            r_trans_count <= 8'd0;
        end else if (w_real) begin
            r_prev_state  <= r_cur_state;
            r_trans_count <= r_trans_count + 8'd1;
        end
    end

    assign o_prev_state  = r_prev_state;
    assign o_trans_count = r_trans_count;
`else
    assign o_prev_state  = 2'b00;
    assign o_trans_count = 8'd0;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_onehot
        assign w_onehot[g] = (r_cur_state == 2'(g));
    end

    assign o_cur_state    = r_cur_state;
    assign o_state_onehot = w_onehot;
    assign o_trans_ack    = r_trans_ack;
    assign o_busy         = w_busy;
    assign o_dwell_cnt    = r_dwell_cnt;

endmodule

// File: tb/tb_fsm_state_sequencer.sv
// Bench for fsm_state_sequencer: a MIN_DWELL=3 instance and a MIN_DWELL=0 instance, directed scenarios plus random traffic.
module tb_fsm_state_sequencer;

`ifdef FSM_SEQ_HISTORY_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif
    localparam int MD0 = 3;
    localparam int MD1 = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ns [2];
    logic       nv [2];
    logic       hd [2];
    logic [1:0] cs [2];
    logic [3:0] oh [2];
    logic       ak [2];
    logic       by [2];
    logic [3:0] dc [2];
    logic [1:0] ps [2];
    logic [7:0] tc [2];

    int checks = 0;
    int errors = 0;

    // reference model state, plain integers
    int m_st [2];
    int m_dw [2];
    int m_ak [2];
    int m_pv [2];
    int m_tc [2];

    always #5 clk = ~clk;

    fsm_state_sequencer #(.DWELL_W(4), .MIN_DWELL(MD0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_next_state(ns[0]), .i_next_valid(nv[0]), .i_hold(hd[0]),
        .o_cur_state(cs[0]), .o_state_onehot(oh[0]), .o_trans_ack(ak[0]), .o_busy(by[0]),
        .o_dwell_cnt(dc[0]), .o_prev_state(ps[0]), .o_trans_count(tc[0]));

    fsm_state_sequencer #(.DWELL_W(4), .MIN_DWELL(MD1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_next_state(ns[1]), .i_next_valid(nv[1]), .i_hold(hd[1]),
        .o_cur_state(cs[1]), .o_state_onehot(oh[1]), .o_trans_ack(ak[1]), .o_busy(by[1]),
        .o_dwell_cnt(dc[1]), .o_prev_state(ps[1]), .o_trans_count(tc[1]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_dw[k] = 0; m_ak[k] = 0; m_pv[k] = 0; m_tc[k] = 0;
        end
    endtask

    // one rising edge: request accepted only when idle, not held, and not right after an ack
    task automatic model_step(input int k);
        int  mind;
        bit  acc;
        mind = (k == 0) ? MD0 : MD1;
        acc  = nv[k] && !hd[k] && (m_dw[k] == 0) && (m_ak[k] == 0);
        if (acc) begin
            m_ak[k] = 1;
            if (int'(ns[k]) != m_st[k]) begin
                m_pv[k] = m_st[k];
                m_tc[k] = (m_tc[k] + 1) % 256;
                m_st[k] = int'(ns[k]);
                m_dw[k] = mind;
            end
        end else begin
            m_ak[k] = 0;
            if (m_dw[k] > 0 && !hd[k]) m_dw[k] = m_dw[k] - 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ns[k] = 2'b00; nv[k] = 1'b0; hd[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cs[k], oh[k], ak[k], by[k], dc[k], ps[k], tc[k]} !== {2'b00, 4'b0001, 1'b0, 1'b0, 4'd0, 2'b00, 8'd0}) begin
                errors++;
                $display("FAIL reset_state dut%0d: got cs=%b oh=%b ak=%b by=%b dc=%0d ps=%b tc=%0d, want 00 0001 0 0 0 00 0",
                         k, cs[k], oh[k], ak[k], by[k], dc[k], ps[k], tc[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({cs[0], oh[0], ak[0], by[0]} !== {2'b00, 4'b0001, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_after_reset: got cs=%b oh=%b ak=%b by=%b, want 00 0001 0 0", cs[0], oh[0], ak[0], by[0]);
        end
    endtask

    task automatic test_real_transition();
        ns[0] = 2'b10; nv[0] = 1'b1;
        step();
        checks++;
        if ({cs[0], oh[0], ak[0], dc[0], by[0]} !== {2'b10, 4'b0100, 1'b1, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL real_trans: got cs=%b oh=%b ak=%b dc=%0d by=%b, want 10 0100 1 3 1", cs[0], oh[0], ak[0], dc[0], by[0]);
        end
        checks++;
        if ({ps[0], tc[0]} !== {2'b00, (HIST ? 8'd1 : 8'd0)}) begin
            errors++;
            $display("FAIL real_trans_hist: got ps=%b tc=%0d, want ps=00 tc=%0d", ps[0], tc[0], HIST ? 1 : 0);
        end
        // new request presented during dwell
        ns[0] = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({ak[0], dc[0], by[0], cs[0]} !== {1'b0, 4'(3 - i), (i != 3), 2'b10}) begin
                errors++;
                $display("FAIL dwell_count N+%0d: got ak=%b dc=%0d by=%b cs=%b, want 0 %0d %0d 10",
                         i, ak[0], dc[0], by[0], cs[0], 3 - i, (i != 3));
            end
        end
        step();
        checks++;
        if ({cs[0], oh[0], ak[0], dc[0]} !== {2'b01, 4'b0010, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL accept_after_dwell: got cs=%b oh=%b ak=%b dc=%0d, want 01 0010 1 3", cs[0], oh[0], ak[0], dc[0]);
        end
        checks++;
        if ({ps[0], tc[0]} !== {(HIST ? 2'b10 : 2'b00), (HIST ? 8'd2 : 8'd0)}) begin
            errors++;
            $display("FAIL second_trans_hist: got ps=%b tc=%0d", ps[0], tc[0]);
        end
        nv[0] = 1'b0;
        repeat (3) step();
        checks++;
        if ({dc[0], by[0], ak[0]} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dwell_done: got dc=%0d by=%b ak=%b, want 0 0 0", dc[0], by[0], ak[0]);
        end
    endtask

    task automatic test_same_state();
        ns[0] = 2'b01; nv[0] = 1'b1;
        step();
        checks++;
        if ({ak[0], cs[0], dc[0], by[0], tc[0]} !== {1'b1, 2'b01, 4'd0, 1'b0, (HIST ? 8'd2 : 8'd0)}) begin
            errors++;
            $display("FAIL same_state: got ak=%b cs=%b dc=%0d by=%b tc=%0d, want 1 01 0 0 %0d",
                     ak[0], cs[0], dc[0], by[0], tc[0], HIST ? 2 : 0);
        end
        nv[0] = 1'b0;
        step();
        checks++;
        if (ak[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse_width: got ak=%b, want 0", ak[0]);
        end
    endtask

    task automatic test_hold_reset();
        ns[0] = 2'b11; nv[0] = 1'b1;
        step();
        nv[0] = 1'b0;
        step();
        checks++;
        if (dc[0] !== 4'd2) begin
            errors++;
            $display("FAIL hold_setup: got dc=%0d, want 2", dc[0]);
        end
        hd[0] = 1'b1; nv[0] = 1'b1; ns[0] = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({dc[0], ak[0], cs[0]} !== {4'd2, 1'b0, 2'b11}) begin
                errors++;
                $display("FAIL hold_freeze cyc%0d: got dc=%0d ak=%b cs=%b, want 2 0 11", i, dc[0], ak[0], cs[0]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cs[k], oh[k], ak[k], by[k], dc[k], ps[k], tc[k]} !== {2'b00, 4'b0001, 1'b0, 1'b0, 4'd0, 2'b00, 8'd0}) begin
                errors++;
                $display("FAIL async_reset dut%0d: got cs=%b oh=%b ak=%b by=%b dc=%0d ps=%b tc=%0d",
                         k, cs[k], oh[k], ak[k], by[k], dc[k], ps[k], tc[k]);
            end
        end
        hd[0] = 1'b0; nv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({cs[0], ak[0], dc[0]} !== {2'b00, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL post_reset_idle: got cs=%b ak=%b dc=%0d", cs[0], ak[0], dc[0]);
        end
    endtask

    task automatic test_min_dwell0();
        logic [1:0] tgt;
        logic [1:0] cur_exp;
        logic       ak_exp;
        tgt = 2'b11; cur_exp = 2'b00;
        ns[1] = tgt; nv[1] = 1'b1; hd[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            ak_exp = ((i % 2) == 0);
            if (ak_exp) cur_exp = tgt;
            checks++;
            if ({cs[1], ak[1], by[1], dc[1]} !== {cur_exp, ak_exp, 1'b0, 4'd0}) begin
                errors++;
                $display("FAIL min_dwell0 edge%0d: got cs=%b ak=%b by=%b dc=%0d, want %b %b 0 0",
                         i, cs[1], ak[1], by[1], dc[1], cur_exp, ak_exp);
            end
            if (ak_exp) begin
                tgt   = ~tgt;
                ns[1] = tgt;
            end
        end
        checks++;
        if (tc[1] !== (HIST ? 8'd4 : 8'd0)) begin
            errors++;
            $display("FAIL min_dwell0_count: got tc=%0d, want %0d", tc[1], HIST ? 4 : 0);
        end
        nv[1] = 1'b0;
    endtask

    task automatic test_random();
        bit         do_rst;
        logic [1:0] e_st;
        logic [3:0] e_oh;
        logic [3:0] e_dw;
        logic [1:0] e_pv;
        logic [7:0] e_tc;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < 2; k++) begin
                nv[k] = ($urandom_range(0, 3) != 0);
                hd[k] = ($urandom_range(0, 4) == 0);
                ns[k] = 2'($urandom_range(0, 3));
                model_step(k);
            end
            step();
            do_rst = ($urandom_range(0, 63) == 0);
            if (do_rst) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
            end
            for (int k = 0; k < 2; k++) begin
                e_st = 2'(m_st[k]);
                e_oh = 4'b0001 << m_st[k];
                e_dw = 4'(m_dw[k]);
                e_pv = HIST ? 2'(m_pv[k]) : 2'b00;
                e_tc = HIST ? 8'(m_tc[k]) : 8'd0;
                checks++;
                if ({cs[k], oh[k], ak[k], by[k], dc[k], ps[k], tc[k]} !==
                    {e_st, e_oh, (m_ak[k] != 0), (m_dw[k] != 0), e_dw, e_pv, e_tc}) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: got cs=%b oh=%b ak=%b by=%b dc=%0d ps=%b tc=%0d, want cs=%b oh=%b ak=%0d by=%0d dc=%0d ps=%b tc=%0d",
                             k, n, cs[k], oh[k], ak[k], by[k], dc[k], ps[k], tc[k],
                             e_st, e_oh, m_ak[k], (m_dw[k] != 0), e_dw, e_pv, e_tc);
                end
            end
            if (do_rst) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        nv[0] = 1'b0; nv[1] = 1'b0; hd[0] = 1'b0; hd[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_real_transition();
        test_same_state();
        test_hold_reset();
        test_min_dwell0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/fsm_state_sequencer.md
# fsm_state_sequencer

Registered state-holding stage placed directly downstream of the combinational next-state priority encoder. It accepts the encoder's 2-bit `next_state` through a valid/ack handshake and commits it to a current-state register. After every real transition it enforces a minimum dwell time. It publishes the current state in binary and one-hot form to the datapath control logic.

## Interface
- `DWELL_W`, 4, width of dwell counter.
- `MIN_DWELL`, 3, cycles the state must be held after a real transition. Legal range is 0 to 2^DWELL_W−1.

- `clk`  in  1  single clock; all flops update on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `next_state`  in  2  requested state from the priority encoder.
- `next_valid`  in  1  request strobe. Must stay high, with `next_state` stable, until `trans_ack` is seen.
- `hold`  in  1  freeze. While high, no request is accepted and the dwell counter does not change.
- `cur_state`  out  2  committed state.
- `state_onehot`  out  4  `1 << cur_state`.
- `trans_ack`  out  1  one-cycle pulse: request accepted.
- `busy`  out  1  dwell in progress, equal to (`dwell_cnt` != 0).
- `dwell_cnt`  out  DWELL_W  remaining dwell cycles.
- `prev_state`  out  2  state before the last real transition. Only meaningful with the history macro.
- `trans_count`  out  8  real-transition counter. Only meaningful with the history macro.

## Operation
- Values after reset:
  - `cur_state`=00 and `state_onehot`=0001.
  - `trans_ack`=0, `busy`=0 and `dwell_cnt`=0.
  - `prev_state`=00 and `trans_count`=0.
- Accept condition, sampled at a rising edge: `next_valid` & !`hold` & !`busy` & !`trans_ack`.
- Real transition: accepted and `next_state` != `cur_state`.
  - `cur_state` ← `next_state`.
  - `dwell_cnt` ← MIN_DWELL.
  - `trans_ack` ← 1.
  - History update, when enabled.
- Same-state request: accepted and `next_state` == `cur_state`.
  - `trans_ack` ← 1.
  - `cur_state`, `dwell_cnt` and history are unchanged.
- Dwell:
  - If `dwell_cnt` != 0 and !`hold`, `dwell_cnt` decrements by 1 per edge.
  - While `hold` is high the count is frozen.
  - The counter never underflows.
- The accept term includes !`trans_ack`, so the edge immediately after an accept can never accept. The requester therefore has one full cycle to drop `next_valid`.
- Internal control states:
  - IDLE (`dwell_cnt`=0): accepts requests.
  - DWELL (`dwell_cnt`>0): requests are stalled.
  - IDLE→DWELL only on a real transition with MIN_DWELL>0.
  - DWELL→IDLE at the edge where the count decrements from 1 to 0.
- MIN_DWELL=0: DWELL is never entered. The throughput limit is then one accept per 2 cycles.
- `next_state` is ignored while `next_valid` is low.
- `trans_ack` is never asserted without an accepted request.
- `hold` rising in the same cycle as a pending request: no accept. The request stays pending until `hold` falls.
- Asynchronous reset mid-dwell or mid-handshake:
  - All outputs immediately return to their reset values.
  - A pending request is lost.
  - The requester must re-present it after `rst_n` rises.

## Timing
- Accept at edge N: `cur_state`, `state_onehot`, `trans_ack`=1 and `dwell_cnt`=MIN_DWELL are all visible after edge N.
- `trans_ack` returns to 0 after edge N+1.
- With no `hold`, `busy` falls after edge N+MIN_DWELL.
- Earliest next accept is edge N+max(2, MIN_DWELL+1).
- Each `hold` cycle during dwell adds one cycle to that bound.
- All outputs come directly from flops, except `state_onehot` and `busy`, which are decoded from registered values with no input-to-output combinational path.

## Configuration
- Macro: `FSM_SEQ_HISTORY_EN`.
- Defined: on every real transition, `prev_state` ← old `cur_state` and `trans_count` increments by 1. The count wraps 255→0.
- Undefined: no history flops are built, and `prev_state` and `trans_count` are tied to 0.
- Handshake, dwell and state behaviour are identical in both builds.

## Test plan
- Reset then idle: hold `rst_n` low 3 cycles, then release with `next_valid`=0 → `cur_state`=00, `state_onehot`=0001, `busy`=0, `trans_ack`=0.
- Real transition with default MIN_DWELL=3: `next_state`=10, `next_valid`=1 held until ack, accepted at edge N.
  - After edge N: `cur_state`=10, `state_onehot`=0100, `trans_ack` pulses 1 cycle, `dwell_cnt`=3.
  - `dwell_cnt` then reads 2, 1, 0; `busy` falls after N+3.
  - With the macro defined: `prev_state`=00 and `trans_count`=1.
- Request during dwell: `next_state`=01 presented at N+1 → no ack until edge N+4; `cur_state` becomes 01 after N+4.
- Same-state request: in state 01 present `next_state`=01 → `trans_ack` pulses, `dwell_cnt` stays 0, `trans_count` unchanged.
- Hold and reset: assert `hold` for 2 cycles with `dwell_cnt`=2 → count frozen at 2 and a pending request is not acked. Then pull `rst_n` low asynchronously mid-dwell → all outputs at reset values without waiting for a clock edge.
- MIN_DWELL=0 with `next_valid` held high and alternating `next_state` values 11/00 → accepts only every other edge, and `busy` never asserts.
